// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps the datapath through key/plaintext load, NUM_ROUNDS
// rounds (the last one with MixColumns bypassed), then holds the result until it is taken.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_in,
   input  logic       abort_in,
   input  logic       out_ready_in,
   output logic       ready_out,
   output logic [3:0] round_out,
   output logic [7:0] rcon_out,
   output logic       load_sel_out,
   output logic       state_en_out,
   output logic       key_en_out,
   output logic       mix_bypass_out,
   output logic       valid_out
);

   // state   | meaning
   // S_IDLE  | waiting for start_in, ready_out high
   // S_LOAD  | datapath loads plaintext and cipher key
   // S_ROUND | full rounds 1..NUM_ROUNDS-1
   // S_FINAL | last round, MixColumns bypassed
   // S_DONE  | ciphertext valid, waiting for out_ready_in
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

   localparam logic [3:0] LAST_FULL_ROUND = 4'(NUM_ROUNDS - 1);
   localparam logic [3:0] FINAL_ROUND     = 4'(NUM_ROUNDS);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [7:0] rcon_q, rcon_d;
   logic       ready_q, load_sel_q, en_q, mix_q, valid_q;

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      case (state_q)
         S_IDLE: begin
            if (start_in && !abort_in) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (abort_in) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ROUND;
               round_d = 4'd1;
               rcon_d  = 8'h01;
            end
         end
         S_ROUND: begin
            if (abort_in) begin
               state_d = S_IDLE;
            end else begin
               round_d = round_q + 4'd1;
               rcon_d  = xtime(rcon_q);
               if (round_q == LAST_FULL_ROUND) state_d = S_FINAL;
            end
         end
         S_FINAL: begin
            state_d = abort_in ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            if (abort_in || out_ready_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Every path back to idle discards the round context.
      if (state_d == S_IDLE) begin
         round_d = 4'd0;
         rcon_d  = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         round_q    <= 4'd0;
         rcon_q     <= 8'h00;
         ready_q    <= 1'b1;
         load_sel_q <= 1'b0;
         en_q       <= 1'b0;
         mix_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         rcon_q     <= rcon_d;
         ready_q    <= (state_d == S_IDLE);
         load_sel_q <= (state_d == S_LOAD);
         en_q       <= (state_d == S_LOAD) || (state_d == S_ROUND) || (state_d == S_FINAL);
         mix_q      <= (state_d == S_FINAL);
         valid_q    <= (state_d == S_DONE);
      end
   end

   assign ready_out      = ready_q;
   assign round_out      = round_q;
   assign rcon_out       = rcon_q;
   assign load_sel_out   = load_sel_q;
   assign state_en_out   = en_q;
   assign key_en_out     = en_q;
   assign mix_bypass_out = mix_q;
   assign valid_out      = valid_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a 10-round and a 14-round instance share stimulus; expected
// outputs come from a table of hand-written vectors and from a cycle model via a scoreboard.
module tb_aes_round_ctrl;

   typedef struct {
      logic       ready, valid, load_sel, state_en, key_en, mix;
      logic [3:0] round;
      logic [7:0] rcon;
      bit         chk_all;
   } outs_t;

   typedef struct {
      string name;
      int    dut;
      outs_t exp;
   } sb_t;

   typedef struct {
      string name;
      logic  r, s, a, o;
      outs_t exp;
   } vec_t;

   localparam int M_IDLE = 0, M_LOAD = 1, M_ROUND = 2, M_FINAL = 3, M_DONE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1, start_in = 1'b0, abort_in = 1'b0, out_ready_in = 1'b0;

   logic       a_ready, a_load_sel, a_state_en, a_key_en, a_mix, a_valid;
   logic [3:0] a_round;
   logic [7:0] a_rcon;
   logic       b_ready, b_load_sel, b_state_en, b_key_en, b_mix, b_valid;
   logic [3:0] b_round;
   logic [7:0] b_rcon;

   aes_round_ctrl #(.NUM_ROUNDS(10)) u_a (
      .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
      .out_ready_in(out_ready_in), .ready_out(a_ready), .round_out(a_round),
      .rcon_out(a_rcon), .load_sel_out(a_load_sel), .state_en_out(a_state_en),
      .key_en_out(a_key_en), .mix_bypass_out(a_mix), .valid_out(a_valid)
   );

   aes_round_ctrl #(.NUM_ROUNDS(14)) u_b (
      .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
      .out_ready_in(out_ready_in), .ready_out(b_ready), .round_out(b_round),
      .rcon_out(b_rcon), .load_sel_out(b_load_sel), .state_en_out(b_state_en),
      .key_en_out(b_key_en), .mix_bypass_out(b_mix), .valid_out(b_valid)
   );

   always #5 clk = ~clk;

   sb_t        sbq[$];
   int         n_vec = 0, n_err = 0, ecnt = 0;
   int         mst[2], mrnd[2], acc[2], nr[2];
   logic       prev_valid[2];
   logic [7:0] rcon_tab[14];
   vec_t       tab[12];

   function automatic outs_t mk(logic rd, logic vl, logic ls, logic se, logic ke, logic mb,
                                logic [3:0] rn, logic [7:0] rc);
      outs_t o;
      o.ready = rd; o.valid = vl; o.load_sel = ls; o.state_en = se; o.key_en = ke;
      o.mix = mb; o.round = rn; o.rcon = rc; o.chk_all = 1'b1;
      return o;
   endfunction

   function automatic outs_t model_outs(int st, int r, int n);
      outs_t o;
      case (st)
         M_LOAD:  o = mk(0, 0, 1, 1, 1, 0, 4'd0, 8'h00);
         M_ROUND: o = mk(0, 0, 0, 1, 1, 0, 4'(r), rcon_tab[r-1]);
         M_FINAL: o = mk(0, 0, 0, 1, 1, 1, 4'(n), rcon_tab[n-1]);
         M_DONE: begin
            // rcon and mix are unconstrained while the result is held
            o = mk(0, 1, 0, 0, 0, 0, 4'(n), 8'h00);
            o.chk_all = 1'b0;
         end
         default: o = mk(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
      endcase
      return o;
   endfunction

   function automatic outs_t actual(int d);
      outs_t o;
      if (d == 0) o = mk(a_ready, a_valid, a_load_sel, a_state_en, a_key_en, a_mix, a_round, a_rcon);
      else        o = mk(b_ready, b_valid, b_load_sel, b_state_en, b_key_en, b_mix, b_round, b_rcon);
      return o;
   endfunction

   task automatic check(input string nm, input int d, input outs_t e);
      outs_t g;
      bit    ok;
      g  = actual(d);
      ok = (g.ready === e.ready) && (g.valid === e.valid) && (g.load_sel === e.load_sel) &&
           (g.state_en === e.state_en) && (g.key_en === e.key_en) && (g.round === e.round);
      if (e.chk_all) ok = ok && (g.mix === e.mix) && (g.rcon === e.rcon);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s dut%0d edge%0d: got rdy=%b vld=%b ls=%b se=%b ke=%b mb=%b rnd=%0d rcon=%h, want rdy=%b vld=%b ls=%b se=%b ke=%b mb=%b rnd=%0d rcon=%h (mb/rcon checked=%0d)",
                  nm, d, ecnt, g.ready, g.valid, g.load_sel, g.state_en, g.key_en, g.mix, g.round, g.rcon,
                  e.ready, e.valid, e.load_sel, e.state_en, e.key_en, e.mix, e.round, e.rcon, e.chk_all);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic a, input logic o,
                       input bit has_tab, input outs_t texp, input string nm);
      sb_t e;
      rst = r; start_in = s; abort_in = a; out_ready_in = o;
      for (int d = 0; d < 2; d++) begin
         if (r) begin
            mst[d] = M_IDLE; acc[d] = -1;
         end else begin
            case (mst[d])
               M_IDLE:  if (s && !a) begin mst[d] = M_LOAD; acc[d] = ecnt + 1; end
               M_LOAD:  if (a) mst[d] = M_IDLE; else begin mst[d] = M_ROUND; mrnd[d] = 1; end
               M_ROUND: if (a) mst[d] = M_IDLE;
                        else if (mrnd[d] == nr[d] - 1) mst[d] = M_FINAL;
                        else mrnd[d] = mrnd[d] + 1;
               M_FINAL: mst[d] = a ? M_IDLE : M_DONE;
               default: if (a || o) mst[d] = M_IDLE;
            endcase
            if (mst[d] == M_IDLE) acc[d] = (s && !a && !r && acc[d] == ecnt + 1) ? acc[d] : -1;
         end
         if (mst[d] == M_IDLE) mrnd[d] = 0;
         e.name = nm; e.dut = d; e.exp = model_outs(mst[d], mrnd[d], nr[d]);
         sbq.push_back(e);
      end
      if (has_tab) begin
         e.name = {nm, "_tab"}; e.dut = 0; e.exp = texp;
         sbq.push_back(e);
      end
      @(posedge clk);
      ecnt++;
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check(e.name, e.dut, e.exp);
      end
      for (int d = 0; d < 2; d++) begin
         logic v;
         v = actual(d).valid;
         if (v && !prev_valid[d] && acc[d] >= 0) begin
            n_vec++;
            if (ecnt - acc[d] != nr[d] + 1) begin
               n_err++;
               $display("FAIL latency dut%0d: valid %0d edges after acceptance, want %0d",
                        d, ecnt - acc[d], nr[d] + 1);
            end
            acc[d] = -1;
         end
         prev_valid[d] = v;
      end
   endtask

   task automatic run(input int n, input logic s0, input logic a, input logic o, input string nm);
      outs_t dummy;
      dummy = mk(0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
      for (int i = 0; i < n; i++) step(1'b0, (i == 0) ? s0 : 1'b0, a, o, 1'b0, dummy, nm);
   endtask

   initial begin
      outs_t idle_o, load_o, dummy;
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
      nr = '{10, 14};
      for (int d = 0; d < 2; d++) begin
         mst[d] = M_IDLE; mrnd[d] = 0; acc[d] = -1; prev_valid[d] = 1'b0;
      end
      idle_o = mk(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
      load_o = mk(0, 0, 1, 1, 1, 0, 4'd0, 8'h00);
      dummy  = idle_o;

      tab[0]  = '{"reset",                1, 0, 0, 0, idle_o};
      tab[1]  = '{"idle",                 0, 0, 0, 0, idle_o};
      tab[2]  = '{"abort_start_in_idle",  0, 1, 1, 0, idle_o};
      tab[3]  = '{"load",                 0, 1, 0, 0, load_o};
      tab[4]  = '{"round1",               0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 4'd1, 8'h01)};
      tab[5]  = '{"round2_start_ignored", 0, 1, 0, 0, mk(0, 0, 0, 1, 1, 0, 4'd2, 8'h02)};
      tab[6]  = '{"round3",               0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 4'd3, 8'h04)};
      tab[7]  = '{"round4",               0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 4'd4, 8'h08)};
      tab[8]  = '{"abort_at_round4",      0, 0, 1, 0, idle_o};
      tab[9]  = '{"restart_load",         0, 1, 0, 0, load_o};
      tab[10] = '{"restart_round1",       0, 0, 0, 1, mk(0, 0, 0, 1, 1, 0, 4'd1, 8'h01)};
      tab[11] = '{"restart_round2",       0, 0, 0, 1, mk(0, 0, 0, 1, 1, 0, 4'd2, 8'h02)};

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dummy, "reset_pre");
      for (int i = 0; i < 12; i++)
         step(tab[i].r, tab[i].s, tab[i].a, tab[i].o, 1'b1, tab[i].exp, tab[i].name);
      run(20, 1'b0, 1'b0, 1'b1, "restart_finish");

      run(20, 1'b1, 1'b0, 1'b1, "nominal");

      // backpressure: hold DONE five cycles with stray start pulses
      run(12, 1'b1, 1'b0, 1'b0, "bp_run");
      for (int i = 0; i < 5; i++)
         step(1'b0, (i % 2 == 0), 1'b0, 1'b0, 1'b0, dummy, "bp_hold");
      run(8, 1'b0, 1'b0, 1'b1, "bp_release");

      run(8, 1'b1, 1'b0, 1'b1, "pre_reset_run");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, idle_o, "reset_at_round7");
      run(20, 1'b1, 1'b0, 1'b1, "post_reset_run");

      run(12, 1'b1, 1'b0, 1'b0, "to_done");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, idle_o, "abort_beats_ready_in_done");
      run(4, 1'b0, 1'b0, 1'b1, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, 10, number of cipher rounds; legal range 2..14.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start_in  input  1  request to encrypt the block/key presented to the datapath.
REQ-005 SHALL have port: abort_in  input  1  cancel the operation in progress.
REQ-006 SHALL have port: out_ready_in  input  1  downstream accepts the result.
REQ-007 SHALL have port: ready_out  output  1  controller idle; start_in is accepted.
REQ-008 SHALL have port: round_out  output  4  current round index, 0..NUM_ROUNDS.
REQ-009 SHALL have port: rcon_out  output  8  round constant for the key expansion of the current round.
REQ-010 SHALL have port: load_sel_out  output  1  1 = datapath loads plaintext/cipher key; 0 = round feedback.
REQ-011 SHALL have port: state_en_out  output  1  state-register write enable.
REQ-012 SHALL have port: key_en_out  output  1  round-key register write enable.
REQ-013 SHALL have port: mix_bypass_out  output  1  1 = MixColumn result bypassed (final round).
REQ-014 SHALL have port: valid_out  output  1  ciphertext in the state register is valid.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL, DONE; all outputs registered or decoded from registered state only, with no input-to-output combinational path.
REQ-016 IDLE: ready_out=1, all enables 0, round_out=0, rcon_out=0x00; start_in=1 -> LOAD.
REQ-017 LOAD, one cycle: load_sel_out=1, state_en_out=1, key_en_out=1, round_out=0, rcon_out=0x00; -> ROUND.
REQ-018 ROUND: rounds 1..NUM_ROUNDS-1, one per cycle; state_en_out=key_en_out=1, load_sel_out=0, mix_bypass_out=0; round_out increments by 1 per cycle; after round NUM_ROUNDS-1 -> FINAL.
REQ-019 FINAL, one cycle: round_out=NUM_ROUNDS, mix_bypass_out=1, state_en_out=key_en_out=1; -> DONE.
REQ-020 DONE: valid_out=1, all enables 0, round_out held at NUM_ROUNDS; out_ready_in=1 -> IDLE on the same edge, so valid_out drops the next cycle.
REQ-021 rcon_out SHALL be 0x01 in round 1; each later round SHALL equal GF(2^8) doubling of the previous value: shift left 1, XOR 0x1B if the old bit 7 was 1, 8-bit truncation. The sequence is 01,02,04,08,10,20,40,80,1B,36,6C,D8,AB,4D.
REQ-022 Latency: start accepted at edge T -> valid_out=1 in the cycle after edge T+NUM_ROUNDS+1, i.e. 12 cycles for the default.
REQ-023 start_in SHALL be ignored outside IDLE, including in DONE.
REQ-024 abort_in=1 in LOAD/ROUND/FINAL/DONE -> IDLE at the next edge; enables and valid_out deassert that cycle; no result is produced.
REQ-025 abort_in has priority over out_ready_in in DONE, and over start_in in IDLE (abort_in in IDLE keeps IDLE).
REQ-026 round counter SHALL never exceed NUM_ROUNDS; the FINAL transition uses compare-equal, with no wrap.

Reset
REQ-027 rst=1 at any edge, in any state, SHALL force IDLE; it has priority over abort_in, start_in and out_ready_in.
REQ-028 Reset values: ready_out=1, valid_out=0, load_sel_out=0, state_en_out=0, key_en_out=0, mix_bypass_out=0, round_out=0, rcon_out=0x00.
REQ-029 Reset asserted mid-operation SHALL discard progress; the first start after reset SHALL run a full sequence from LOAD.

Verification
REQ-030 Nominal run: start_in pulse in IDLE, out_ready_in=1 -> LOAD 1 cycle; round_out 1..9 with rcon 01..1B and mix_bypass 0; round 10 with rcon 36 and mix_bypass 1; valid_out 1 cycle 12 after acceptance; then ready_out=1.
REQ-031 Backpressure: out_ready_in=0 for 5 cycles in DONE -> valid_out held 1 and round_out=10 all 5 cycles; start_in pulses ignored; release -> IDLE next cycle.
REQ-032 Abort: abort_in at round 4 -> next cycle IDLE, ready_out=1, enables 0, valid_out never asserts; immediate restart completes normally.
REQ-033 Reset mid-run: rst at round 7 -> next cycle all REQ-028 values; new start gives full 12-cycle latency.
REQ-034 Simultaneous: in DONE, abort_in=1 with out_ready_in=1 -> IDLE with no result; in IDLE, abort_in=1 with start_in=1 -> remains IDLE.
REQ-035 Parameter: NUM_ROUNDS=14 -> round_out reaches 14, final rcon 0x4D, mix_bypass only in round 14, latency 16 cycles.
